// File: rtl/heq_pkg.sv
// Shared constants and FSM encoding for the
// histogram-equalisation LUT generator.
package heq_pkg;

   localparam int BINS         = 256;
   localparam int CDF_PER_WORD = 4;
   localparam int LUT_PER_WORD = 16;
   localparam int PAIRS        = BINS / (2 * CDF_PER_WORD);
   localparam int NUM_W        = 32;
   localparam int DEN_W        = 24;
   localparam int ADDR_W       = 16;
   localparam int DATA_W       = 128;

   localparam logic [NUM_W-1:0] SCALE = 32'd255;

   typedef enum logic [2:0] {
      S_IDLE,
      S_MIN_RD,
      S_MIN_CHK,
      S_MAP_RD,
      S_MAP_DIV,
      S_MAP_WR,
      S_DONE
   } state_t;

endpackage

// File: rtl/heq_div8.sv
// Restoring divider: 32-bit numerator over 24-bit denominator,
// 8 quotient bits, saturates to 255; valid 9 cycles after load.
module heq_div8
   import heq_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [NUM_W-1:0] num,
   input  logic [DEN_W-1:0] den,
   output logic [7:0]       q,
   output logic             valid
);

   logic [DEN_W:0]   rem;
   logic [DEN_W:0]   shifted;
   logic [DEN_W-1:0] dreg;
   logic [7:0]       low;
   logic [7:0]       quo;
   logic [3:0]       cnt;
   logic             sat;
   logic             ge;

   // One restoring step: shift in next numerator bit and trial-subtract.
   always_comb begin
      shifted = {rem[DEN_W-1:0], low[7]};
      ge      = shifted >= {1'b0, dreg};
   end

   // Load operands, then run 8 iterations and pulse valid.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rem   <= '0;
         dreg  <= '0;
         low   <= '0;
         quo   <= '0;
         cnt   <= '0;
         sat   <= 1'b0;
         valid <= 1'b0;
      end else begin
         valid <= 1'b0;
         if (load) begin
            rem  <= {1'b0, num[NUM_W-1:8]};
            low  <= num[7:0];
            dreg <= den;
            quo  <= '0;
            sat  <= num[NUM_W-1:8] >= den;
            cnt  <= 4'd8;
         end else if (cnt != 4'd0) begin
            if (ge) begin
               rem <= shifted - {1'b0, dreg};
               quo <= {quo[6:0], 1'b1};
            end else begin
               rem <= shifted;
               quo <= {quo[6:0], 1'b0};
            end
            low <= {low[6:0], 1'b0};
            cnt <= cnt - 4'd1;
            if (cnt == 4'd1)
               valid <= 1'b1;
         end
      end
   end

   assign q = sat ? 8'hFF : quo;

endmodule

// File: rtl/heq_lut_gen.sv
// Histogram-equalisation LUT generator (CDF -> 8-bit LUT).
// Define HEQ_ROUND_EN for round-to-nearest instead of truncation.
module heq_lut_gen
   import heq_pkg::*;
#(
   parameter logic [NUM_W-1:0]  NUM_PIXELS = 32'd8294400,
   parameter logic [ADDR_W-1:0] CDF_BASE   = 16'd64,
   parameter logic [ADDR_W-1:0] LUT_BASE   = 16'd128,
   parameter int                RD_LAT     = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [DATA_W-1:0] scratchmem_input1,
   input  logic [DATA_W-1:0] scratchmem_input2,
   output logic [ADDR_W-1:0] ReadAddress1,
   output logic [ADDR_W-1:0] ReadAddress2,
   output logic              WE,
   output logic [ADDR_W-1:0] WriteAddress,
   output logic [DATA_W-1:0] WriteBus,
   output logic              busy,
   output logic              done,
   output logic [NUM_W-1:0]  cdf_min
);

   localparam logic [3:0] LAT  = 4'(RD_LAT);
   localparam logic [4:0] LAST = 5'(PAIRS - 1);

   state_t           state, state_n;
   logic [4:0]       pidx, pidx_n;
   logic [3:0]       wcnt;
   logic             half;
   logic [3:0]       bidx;
   logic             inflight;
   logic [NUM_W-1:0] cdf_r [2*2*CDF_PER_WORD];
   logic [7:0]       ent [LUT_PER_WORD];
   logic [DEN_W-1:0] den;
   logic             den_zero;

   logic             rd_ready;
   logic             hit;
   logic [NUM_W-1:0] hit_val;
   logic [NUM_W-1:0] den_full;
   logic [NUM_W-1:0] cur, diff, num;
   logic [DATA_W-1:0] lut_word;
   logic             div_load;
   logic             div_valid;
   logic [7:0]       div_q;

   assign rd_ready = (wcnt == LAT);

   // Lowest-numbered non-zero bin of the current 8-bin pair.
   always_comb begin
      hit     = 1'b0;
      hit_val = '0;
      for (int k = 2*CDF_PER_WORD-1; k >= 0; k--) begin
         if (cdf_r[k] != '0) begin
            hit     = 1'b1;
            hit_val = cdf_r[k];
         end
      end
      den_full = NUM_PIXELS - hit_val;
   end

   // Scaled numerator for the bin being mapped; clamps below cdf_min.
   always_comb begin
      cur  = cdf_r[bidx];
      diff = (cur >= cdf_min) ? cur - cdf_min : '0;
      num  = diff * SCALE;
`ifdef HEQ_ROUND_EN
      num  = num + {9'd0, den[DEN_W-1:1]};
`endif
   end

   // Pack 16 entries, bin 16j in the top byte.
   always_comb begin
      lut_word = '0;
      for (int k = 0; k < LUT_PER_WORD; k++)
         lut_word[DATA_W-1-8*k -: 8] = ent[k];
   end

   // Next-state, read-pair index and divider load.
   always_comb begin
      state_n  = state;
      pidx_n   = pidx;
      div_load = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (start) begin
               state_n = S_MIN_RD;
               pidx_n  = '0;
            end
         end
         S_MIN_RD: begin
            if (rd_ready)
               state_n = S_MIN_CHK;
         end
         S_MIN_CHK: begin
            if (hit || pidx == LAST) begin
               state_n = S_MAP_RD;
               pidx_n  = '0;
            end else begin
               state_n = S_MIN_RD;
               pidx_n  = pidx + 5'd1;
            end
         end
         S_MAP_RD: begin
            if (rd_ready) begin
               if (!half)
                  pidx_n = pidx + 5'd1;
               else
                  state_n = S_MAP_DIV;
            end
         end
         S_MAP_DIV: begin
            div_load = !den_zero && !inflight;
            if ((den_zero || div_valid) && bidx == 4'd15)
               state_n = S_MAP_WR;
         end
         S_MAP_WR: begin
            if (pidx == LAST) begin
               state_n = S_DONE;
            end else begin
               state_n = S_MAP_RD;
               pidx_n  = pidx + 5'd1;
            end
         end
         S_DONE:  state_n = S_IDLE;
         default: state_n = S_IDLE;
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state <= S_IDLE;
      else
         state <= state_n;
   end

   // Datapath: reads, min search, mapping and LUT writes.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pidx         <= '0;
         wcnt         <= '0;
         half         <= 1'b0;
         bidx         <= '0;
         inflight     <= 1'b0;
         den          <= '0;
         den_zero     <= 1'b0;
         cdf_min      <= '0;
         ReadAddress1 <= CDF_BASE;
         ReadAddress2 <= CDF_BASE + 16'd1;
         WE           <= 1'b0;
         WriteAddress <= '0;
         WriteBus     <= '0;
         busy         <= 1'b0;
         done         <= 1'b0;
         for (int k = 0; k < 2*2*CDF_PER_WORD; k++)
            cdf_r[k] <= '0;
         for (int k = 0; k < LUT_PER_WORD; k++)
            ent[k] <= '0;
      end else begin
         WE           <= 1'b0;
         done         <= 1'b0;
         pidx         <= pidx_n;
         ReadAddress1 <= CDF_BASE + {10'd0, pidx_n, 1'b0};
         ReadAddress2 <= CDF_BASE + {10'd0, pidx_n, 1'b1};

         if (state_n != state || pidx_n != pidx)
            wcnt <= '0;
         else if (wcnt != LAT)
            wcnt <= wcnt + 4'd1;

         if (state == S_IDLE && start) begin
            busy     <= 1'b1;
            cdf_min  <= '0;
            half     <= 1'b0;
            bidx     <= '0;
            inflight <= 1'b0;
         end

         if (rd_ready && (state == S_MIN_RD ||
             (state == S_MAP_RD && !half))) begin
            for (int k = 0; k < CDF_PER_WORD; k++) begin
               cdf_r[k]   <= scratchmem_input1[DATA_W-1-32*k -: 32];
               cdf_r[k+4] <= scratchmem_input2[DATA_W-1-32*k -: 32];
            end
         end

         if (rd_ready && state == S_MAP_RD && half) begin
            for (int k = 0; k < CDF_PER_WORD; k++) begin
               cdf_r[k+8]  <= scratchmem_input1[DATA_W-1-32*k -: 32];
               cdf_r[k+12] <= scratchmem_input2[DATA_W-1-32*k -: 32];
            end
         end

         if (rd_ready && state == S_MAP_RD)
            half <= !half;

         if (state == S_MIN_CHK && (hit || pidx == LAST)) begin
            cdf_min  <= hit_val;
            den      <= den_full[DEN_W-1:0];
            den_zero <= den_full == '0;
         end

         if (state == S_MAP_DIV) begin
            if (den_zero) begin
               ent[bidx] <= {pidx[4:1], bidx};
               bidx      <= bidx + 4'd1;
            end else if (div_load) begin
               inflight  <= 1'b1;
            end else if (div_valid) begin
               ent[bidx] <= div_q;
               inflight  <= 1'b0;
               bidx      <= bidx + 4'd1;
            end
         end

         if (state == S_MAP_WR) begin
            WE           <= 1'b1;
            WriteAddress <= LUT_BASE + {12'd0, pidx[4:1]};
            WriteBus     <= lut_word;
         end

         if (state == S_DONE) begin
            done <= 1'b1;
            busy <= 1'b0;
         end
      end
   end

   heq_div8 u_div (
      .clk   (clk),
      .reset (reset),
      .load  (div_load),
      .num   (num),
      .den   (den),
      .q     (div_q),
      .valid (div_valid)
   );

endmodule

// File: tb/tb_heq_lut_gen.sv
// Scoreboard bench for heq_lut_gen: directed CDF tables with
// hand-derived LUTs, mid-run reset and start-while-busy cases.
module tb_heq_lut_gen;

   localparam logic [31:0] N = 32'd8294400;

   typedef struct packed {
      logic [15:0]  addr;
      logic [127:0] data;
   } wr_t;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         start = 1'b0;
   logic [127:0] scratchmem_input1 = '0;
   logic [127:0] scratchmem_input2 = '0;
   logic [15:0]  ReadAddress1, ReadAddress2;
   logic         WE;
   logic [15:0]  WriteAddress;
   logic [127:0] WriteBus;
   logic         busy, done;
   logic [31:0]  cdf_min;

   logic [127:0] mem [256];
   logic [31:0]  cdf [256];
   int           el  [256];

   wr_t          exp_q [$];
   logic [31:0]  min_q [$];
   wr_t          mon_e;
   logic [31:0]  mon_m;

   int checks = 0;
   int errors = 0;
   int we_cnt = 0;
   int done_cnt = 0;

   heq_lut_gen dut (
      .clk               (clk),
      .reset             (reset),
      .start             (start),
      .scratchmem_input1 (scratchmem_input1),
      .scratchmem_input2 (scratchmem_input2),
      .ReadAddress1      (ReadAddress1),
      .ReadAddress2      (ReadAddress2),
      .WE                (WE),
      .WriteAddress      (WriteAddress),
      .WriteBus          (WriteBus),
      .busy              (busy),
      .done              (done),
      .cdf_min           (cdf_min)
   );

   always #5 clk = ~clk;

   // Scratch memory with one cycle of read latency.
   always @(posedge clk) begin
      scratchmem_input1 <= mem[ReadAddress1[7:0]];
      scratchmem_input2 <= mem[ReadAddress2[7:0]];
   end

   task automatic check(input string name,
                        input logic [127:0] act,
                        input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, want %h", name, act, exp);
      end
   endtask

   // Monitor: compare every LUT write and every done pulse.
   always @(negedge clk) begin
      if (!reset) begin
         if (WE) begin
            we_cnt++;
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_we: addr %0d", WriteAddress);
            end else begin
               mon_e = exp_q.pop_front();
               check("wr_addr", {112'd0, WriteAddress}, {112'd0, mon_e.addr});
               check("wr_data", WriteBus, mon_e.data);
            end
         end
         if (done) begin
            done_cnt++;
            check("busy_at_done", {127'd0, busy}, 128'd0);
            if (min_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_done: cdf_min %0d", cdf_min);
            end else begin
               mon_m = min_q.pop_front();
               check("cdf_min", {96'd0, cdf_min}, {96'd0, mon_m});
            end
         end
      end
   end

   task automatic load_mem();
      for (int w = 0; w < 64; w++)
         mem[64+w] = {cdf[4*w], cdf[4*w+1], cdf[4*w+2], cdf[4*w+3]};
   endtask

   task automatic push_exp(input logic [31:0] expmin);
      wr_t it;
      for (int j = 0; j < 16; j++) begin
         it.addr = 16'(128 + j);
         it.data = '0;
         for (int k = 0; k < 16; k++)
            it.data[127-8*k -: 8] = 8'(el[16*j+k]);
         exp_q.push_back(it);
      end
      min_q.push_back(expmin);
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_ra1"},  {112'd0, ReadAddress1}, 128'd64);
      check({tag, "_ra2"},  {112'd0, ReadAddress2}, 128'd65);
      check({tag, "_we"},   {127'd0, WE}, 128'd0);
      check({tag, "_wa"},   {112'd0, WriteAddress}, 128'd0);
      check({tag, "_wb"},   WriteBus, 128'd0);
      check({tag, "_busy"}, {127'd0, busy}, 128'd0);
      check({tag, "_done"}, {127'd0, done}, 128'd0);
      check({tag, "_min"},  {96'd0, cdf_min}, 128'd0);
   endtask

   task automatic run(input logic [31:0] expmin, input bit spam);
      int w0, d0;
      load_mem();
      push_exp(expmin);
      w0 = we_cnt;
      d0 = done_cnt;
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      check("busy_after_start", {127'd0, busy}, 128'd1);
      for (int c = 0; c < 8000 && done_cnt == d0; c++) begin
         @(negedge clk);
         start = spam && c < 2000 && (c % 41) == 3;
      end
      start = 1'b0;
      repeat (5) @(negedge clk);
      check("we_count",    128'(we_cnt - w0), 128'd16);
      check("done_count",  128'(done_cnt - d0), 128'd1);
      check("queue_empty", 128'(exp_q.size()), 128'd0);
      exp_q.delete();
      min_q.delete();
   endtask

   task automatic set_flat();
      for (int i = 0; i < 256; i++) begin
         cdf[i] = 32'(32400 * (i + 1));
         el[i]  = i;
      end
   endtask

   initial begin
      int w0;
      for (int a = 0; a < 256; a++) mem[a] = '0;

      repeat (3) @(negedge clk);
      check_reset_vals("rst");
      reset = 1'b0;
      repeat (2) @(negedge clk);

      // start together with reset is lost
      reset = 1'b1;
      start = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      start = 1'b0;
      repeat (3) @(negedge clk);
      check("start_in_reset", {127'd0, busy}, 128'd0);

      // flat histogram: (32400*i*255)/8262000 = i
      set_flat();
      run(32'd32400, 1'b0);

      // single-valued frame -> identity
      for (int i = 0; i < 256; i++) begin
         cdf[i] = (i < 37) ? 32'd0 : N;
         el[i]  = i;
      end
      run(N, 1'b0);

      // two values at bins 10 and 200
      for (int i = 0; i < 256; i++) begin
         cdf[i] = (i < 10) ? 32'd0 : (i < 200) ? N / 2 : N;
         el[i]  = (i < 200) ? 0 : 255;
      end
      run(N / 2, 1'b0);

      // 48791*255/8294399 = 1.50001: truncates to 1, rounds to 2
      for (int i = 0; i < 256; i++) begin
         cdf[i] = N;
         el[i]  = 255;
      end
      cdf[0] = 32'd0;
      cdf[1] = 32'd1;
      cdf[2] = 32'd48792;
      el[0]  = 0;
      el[1]  = 0;
`ifdef HEQ_ROUND_EN
      el[2]  = 2;
`else
      el[2]  = 1;
`endif
      run(32'd1, 1'b0);

      // all-zero CDF: full scan, cdf_min=0, LUT all zero
      for (int i = 0; i < 256; i++) begin
         cdf[i] = 32'd0;
         el[i]  = 0;
      end
      run(32'd0, 1'b0);

      // reset during the divide phase of word 5
      set_flat();
      load_mem();
      push_exp(32'd32400);
      w0 = we_cnt;
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      for (int c = 0; c < 4000 && (we_cnt - w0) < 5; c++)
         @(negedge clk);
      repeat (20) @(negedge clk);
      reset = 1'b1;
      #1;
      check_reset_vals("abort");
      repeat (3) @(negedge clk);
      check("abort_we_count", 128'(we_cnt - w0), 128'd5);
      exp_q.delete();
      min_q.delete();
      reset = 1'b0;
      repeat (2) @(negedge clk);
      check("abort_idle", {127'd0, busy}, 128'd0);
      run(32'd32400, 1'b0);

      // start pulsed while busy is ignored
      set_flat();
      run(32'd32400, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
